// File: rtl/hazard_sched_pkg.sv
// Shared definitions for the pipeline scheduler: FSM state type, register-zero
// constant, default mult/div latencies and the operand-match helper.
package hazard_sched_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } sched_state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam int unsigned MULT_LAT_DEF = 4;
    localparam int unsigned DIV_LAT_DEF  = 32;

    // $zero is hardwired, so a read of it can never depend on an older write.
    function automatic logic reg_match(input logic       use_reg,
                                       input logic [4:0] id_reg,
                                       input logic [4:0] dst_reg);
        return use_reg && (id_reg != REG_ZERO) && (id_reg == dst_reg);
    endfunction

endpackage

// File: rtl/hazard_sched_md_busy_cnt.sv
// HI/LO occupancy counter: tracks how many cycles remain until the
// multi-cycle mult/div unit delivers its result.
module md_busy_cnt
    import hazard_sched_pkg::*;
#(
    parameter int unsigned MULT_LAT = MULT_LAT_DEF,
    parameter int unsigned DIV_LAT  = DIV_LAT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic is_div,
    output logic busy
);

    localparam int unsigned MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

    logic [CNT_W-1:0] mdc;
    logic [CNT_W-1:0] mdc_next;

    // A new issue always reloads, superseding any operation still in flight.
    always_comb begin
        mdc_next = mdc;
        if (start) begin
            mdc_next = is_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
        end else if (mdc != '0) begin
            mdc_next = mdc - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mdc  <= '0;
            busy <= 1'b0;
        end else begin
            mdc  <= mdc_next;
            busy <= (mdc_next != '0);
        end
    end

endmodule

// File: rtl/hazard_sched.sv
// Pipeline scheduler for the 5-stage MIPS core: load-use, ID-branch and HI/LO
// stalls, plus IF/ID and ID/EX flushing on exception or ERET redirect.
module hazard_sched
    import hazard_sched_pkg::*;
#(
    parameter int unsigned MULT_LAT  = MULT_LAT_DEF,
    parameter int unsigned DIV_LAT   = DIV_LAT_DEF,
    parameter int unsigned FLUSH_LEN = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] ID_rs,
    input  logic [4:0] ID_rt,
    input  logic       ID_useRs,
    input  logic       ID_useRt,
    input  logic       ID_isBranch,
    input  logic       ID_useHiLo,
    input  logic       EX_regWrite,
    input  logic       EX_memRead,
    input  logic [4:0] EX_rw,
    input  logic       MEM_memRead,
    input  logic [4:0] MEM_rw,
    input  logic       md_start,
    input  logic       md_isDiv,
    input  logic       exc_req,
    input  logic       eret,
    output logic       pc_we,
    output logic       ifid_hold,
    output logic       ifid_flush,
    output logic       idex_flush,
    output logic       md_busy
);

    localparam int unsigned    FC_W      = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;
    localparam logic [FC_W-1:0] FC_RELOAD = FC_W'(FLUSH_LEN - 1);

    sched_state_e    state;
    logic [FC_W-1:0] fc;

    logic ex_match;
    logic mem_match;
    logic hz_load;
    logic hz_br;
    logic hz_md;
    logic stall;
    logic trap;
    logic redirect;

    md_busy_cnt #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT)
    ) u_md_busy_cnt (
        .clk    (clk),
        .rst    (rst),
        .start  (md_start),
        .is_div (md_isDiv),
        .busy   (md_busy)
    );

    assign ex_match  = reg_match(ID_useRs, ID_rs, EX_rw)  | reg_match(ID_useRt, ID_rt, EX_rw);
    assign mem_match = reg_match(ID_useRs, ID_rs, MEM_rw) | reg_match(ID_useRt, ID_rt, MEM_rw);

    // Branches resolve in ID, so they also wait on EX ALU results and on loads in MEM.
    assign hz_load = EX_memRead & ex_match;
    assign hz_br   = ID_isBranch & ((EX_regWrite & ex_match) | (MEM_memRead & mem_match));
    assign hz_md   = ID_useHiLo & md_busy;
    assign stall   = hz_load | hz_br | hz_md;

    assign trap     = exc_req | eret;
    assign redirect = trap | (state == FLUSH);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
            fc    <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (trap) begin
                        state <= FLUSH;
                        fc    <= FC_RELOAD;
                    end
                end
                FLUSH: begin
                    if (trap) begin
                        fc <= FC_RELOAD;
                    end else if (fc == '0) begin
                        state <= RUN;
                    end else begin
                        fc <= fc - FC_W'(1);
                    end
                end
                default: begin
                    state <= RUN;
                    fc    <= '0;
                end
            endcase
        end
    end

    // Redirect outranks every stall; reset forces a frozen, flushed front end.
    always_comb begin
        pc_we      = 1'b1;
        ifid_hold  = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        if (!rst) begin
            pc_we      = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (redirect) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (stall) begin
            pc_we      = 1'b0;
            ifid_hold  = 1'b1;
            idex_flush = 1'b1;
        end
    end

endmodule
